// File: rtl/sipo_shift_register.sv
// Serial-in / parallel-out deserializer with a separate output hold register,
// so the next word can be assembled while the previous one waits for the consumer.
module sipo_shift_register #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serial_in,
    input  logic         in_valid,
    input  logic         start,
    output logic         in_ready,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sync_err
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  shreg_q, shreg_d;
    logic [N-1:0]  pout_q, pout_d;
    logic [N-1:0]  shifted, seed;
    logic [CW-1:0] count_q, count_d;
    logic          ovalid_q, ovalid_d;
    logic          serr_q, serr_d;
    logic          accept, restart, complete;
    logic          at_last, mid_word;

    always_comb begin
        at_last  = (count_q == LAST);
        mid_word = (count_q != '0);
        // Only the word-completing bit can be blocked by an unconsumed held word.
        in_ready = ~(ovalid_q & ~out_ready & at_last);
        accept   = in_valid & in_ready;
        restart  = accept & start;
        complete = accept & at_last & ~(start & mid_word);

        if (MSB_FIRST) begin
            shifted = {shreg_q[N-2:0], serial_in};
            seed    = {{(N-1){1'b0}}, serial_in};
        end else begin
            shifted = {serial_in, shreg_q[N-1:1]};
            seed    = {serial_in, {(N-1){1'b0}}};
        end

        shreg_d  = shreg_q;
        count_d  = count_q;
        pout_d   = pout_q;
        ovalid_d = ovalid_q;
        serr_d   = restart & mid_word;

        if (ovalid_q & out_ready) begin
            ovalid_d = 1'b0;
        end

        if (restart) begin
            shreg_d = seed;
            count_d = CW'(1);
        end else if (accept) begin
            shreg_d = shifted;
            count_d = complete ? '0 : count_q + CW'(1);
        end

        // A completing word overrides the consume above: back-to-back, no bubble.
        if (complete) begin
            pout_d   = shifted;
            ovalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            count_q  <= '0;
            pout_q   <= '0;
            ovalid_q <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            pout_q   <= pout_d;
            ovalid_q <= ovalid_d;
            serr_q   <= serr_d;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = ovalid_q;
    assign sync_err     = serr_q;
endmodule
